map_region_scanner: RTL

// Parametrised, table-driven successor of the fixed ladder/ramp decoder.
// On each sample strobe, latches the character position.

---
 rtl/map_region_scanner_if.sv | 27 ++
 rtl/map_region_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_region_scanner_if.sv
// Bundles the sample request and the published scan results that pass between the
// position register, the scanner and the character movement FSM.
interface map_region_scanner_if;
  logic        sample;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        busy;
  logic        done;
  logic        ladder;
  logic [11:0] limit_ypos_min;
  logic [11:0] limit_ypos_max;
  logic [1:0]  ramp;
  logic        end_of_ramp;
  logic [11:0] landing_ypos;

  modport slave (
    input  sample, xpos, ypos,
    output busy, done, ladder, limit_ypos_min, limit_ypos_max,
           ramp, end_of_ramp, landing_ypos
  );

  modport master (
    output sample, xpos, ypos,
    input  busy, done, ladder, limit_ypos_min, limit_ypos_max,
           ramp, end_of_ramp, landing_ypos
  );
endinterface

// File: rtl/map_region_scanner.sv
// Table-driven region lookup: latches the character position on a sample strobe, walks
// one region entry per clock and publishes ladder/ramp/end-of-ramp results in one cycle.
module map_region_scanner #(
  parameter int unsigned                NUM_REGIONS = 8,
  parameter logic [NUM_REGIONS*2-1:0]   RGN_KIND    = '0,
  parameter logic [NUM_REGIONS*12-1:0]  RGN_XMIN    = '0,
  parameter logic [NUM_REGIONS*12-1:0]  RGN_XMAX    = '0,
  parameter logic [NUM_REGIONS*12-1:0]  RGN_YMIN    = '0,
  parameter logic [NUM_REGIONS*12-1:0]  RGN_YMAX    = '0,
  parameter logic [NUM_REGIONS*12-1:0]  RGN_AUX0    = '0,
  parameter logic [NUM_REGIONS*12-1:0]  RGN_AUX1    = '0
) (
  input logic                 clk,
  input logic                 rst,
  map_region_scanner_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int unsigned TBL_N = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGIONS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [1:0] K_LADDER = 2'd0;
  localparam logic [1:0] K_UP     = 2'd1;
  localparam logic [1:0] K_DOWN   = 2'd2;
  localparam logic [1:0] K_END    = 2'd3;

  logic [1:0]  kind_a [TBL_N];
  logic [11:0] xmin_a [TBL_N];
  logic [11:0] xmax_a [TBL_N];
  logic [11:0] ymin_a [TBL_N];
  logic [11:0] ymax_a [TBL_N];
  logic [11:0] aux0_a [TBL_N];
  logic [11:0] aux1_a [TBL_N];

  // Padding entries have XMIN>XMAX so they can never hit, even if indexed.
  for (genvar i = 0; i < TBL_N; i++) begin : g_tbl
    if (i < NUM_REGIONS) begin : g_used
      assign kind_a[i] = RGN_KIND[2*i +: 2];
      assign xmin_a[i] = RGN_XMIN[12*i +: 12];
      assign xmax_a[i] = RGN_XMAX[12*i +: 12];
      assign ymin_a[i] = RGN_YMIN[12*i +: 12];
      assign ymax_a[i] = RGN_YMAX[12*i +: 12];
      assign aux0_a[i] = RGN_AUX0[12*i +: 12];
      assign aux1_a[i] = RGN_AUX1[12*i +: 12];
    end else begin : g_pad
      assign kind_a[i] = K_LADDER;
      assign xmin_a[i] = 12'hFFF;
      assign xmax_a[i] = 12'h000;
      assign ymin_a[i] = 12'hFFF;
      assign ymax_a[i] = 12'h000;
      assign aux0_a[i] = 12'h000;
      assign aux1_a[i] = 12'h000;
    end
  end

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic [11:0]      x_q, x_d, y_q, y_d;
  logic             acc_ladder_q, acc_ladder_d, acc_end_q, acc_end_d;
  logic [11:0]      acc_lmin_q, acc_lmin_d, acc_lmax_q, acc_lmax_d, acc_land_q, acc_land_d;
  logic [1:0]       acc_ramp_q, acc_ramp_d;
  logic             busy_q, busy_d, done_q, done_d, ladder_q, ladder_d, eor_q, eor_d;
  logic [11:0]      lmin_q, lmin_d, lmax_q, lmax_d, land_q, land_d;
  logic [1:0]       ramp_q, ramp_d;

  logic [1:0]  cur_kind_s;
  logic        hit_s, lad_win_s, rmp_win_s, end_win_s;
  logic        m_ladder_s, m_end_s;
  logic [11:0] m_lmin_s, m_lmax_s, m_land_s;
  logic [1:0]  m_ramp_s;

  // A class only takes the current entry if no lower index already claimed it.
  assign cur_kind_s = kind_a[idx_q];
  assign hit_s      = (x_q >= xmin_a[idx_q]) && (x_q <= xmax_a[idx_q]) &&
                      (y_q >= ymin_a[idx_q]) && (y_q <= ymax_a[idx_q]);
  assign lad_win_s  = hit_s && (cur_kind_s == K_LADDER) && !acc_ladder_q;
  assign rmp_win_s  = hit_s && ((cur_kind_s == K_UP) || (cur_kind_s == K_DOWN)) &&
                      (acc_ramp_q == 2'b00);
  assign end_win_s  = hit_s && (cur_kind_s == K_END) && !acc_end_q;

  assign m_ladder_s = acc_ladder_q | lad_win_s;
  assign m_lmin_s   = lad_win_s ? aux0_a[idx_q] : acc_lmin_q;
  assign m_lmax_s   = lad_win_s ? aux1_a[idx_q] : acc_lmax_q;
  assign m_ramp_s   = rmp_win_s ? ((cur_kind_s == K_UP) ? 2'b01 : 2'b10) : acc_ramp_q;
  assign m_end_s    = acc_end_q | end_win_s;
  assign m_land_s   = end_win_s ? aux0_a[idx_q] : acc_land_q;

  // Next-state logic for the scan FSM, accumulators and published results.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    x_d          = x_q;
    y_d          = y_q;
    acc_ladder_d = acc_ladder_q;
    acc_lmin_d   = acc_lmin_q;
    acc_lmax_d   = acc_lmax_q;
    acc_ramp_d   = acc_ramp_q;
    acc_end_d    = acc_end_q;
    acc_land_d   = acc_land_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ladder_d     = ladder_q;
    lmin_d       = lmin_q;
    lmax_d       = lmax_q;
    ramp_d       = ramp_q;
    eor_d        = eor_q;
    land_d       = land_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample || pending_q) begin
          x_d          = bus.xpos;
          y_d          = bus.ypos;
          pending_d    = 1'b0;
          acc_ladder_d = 1'b0;
          acc_lmin_d   = 12'd0;
          acc_lmax_d   = 12'd0;
          acc_ramp_d   = 2'b00;
          acc_end_d    = 1'b0;
          acc_land_d   = 12'd0;
          idx_d        = '0;
          busy_d       = 1'b1;
          state_d      = ST_SCAN;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_SCAN: begin
        pending_d    = pending_q | bus.sample;
        acc_ladder_d = m_ladder_s;
        acc_lmin_d   = m_lmin_s;
        acc_lmax_d   = m_lmax_s;
        acc_ramp_d   = m_ramp_s;
        acc_end_d    = m_end_s;
        acc_land_d   = m_land_s;
        // Results are registered on the last entry so they appear together with done.
        if (idx_q == LAST_IDX) begin
          state_d  = ST_COMMIT;
          done_d   = 1'b1;
          ladder_d = m_ladder_s;
          lmin_d   = m_ladder_s ? m_lmin_s : lmin_q;
          lmax_d   = m_ladder_s ? m_lmax_s : lmax_q;
          ramp_d   = m_ramp_s;
          eor_d    = m_end_s;
          land_d   = m_end_s ? m_land_s : land_q;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_COMMIT: begin
        pending_d = pending_q | bus.sample;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        pending_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      x_q          <= 12'd0;
      y_q          <= 12'd0;
      acc_ladder_q <= 1'b0;
      acc_lmin_q   <= 12'd0;
      acc_lmax_q   <= 12'd0;
      acc_ramp_q   <= 2'b00;
      acc_end_q    <= 1'b0;
      acc_land_q   <= 12'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ladder_q     <= 1'b0;
      lmin_q       <= 12'd0;
      lmax_q       <= 12'd0;
      ramp_q       <= 2'b00;
      eor_q        <= 1'b0;
      land_q       <= 12'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_ladder_q <= acc_ladder_d;
      acc_lmin_q   <= acc_lmin_d;
      acc_lmax_q   <= acc_lmax_d;
      acc_ramp_q   <= acc_ramp_d;
      acc_end_q    <= acc_end_d;
      acc_land_q   <= acc_land_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ladder_q     <= ladder_d;
      lmin_q       <= lmin_d;
      lmax_q       <= lmax_d;
      ramp_q       <= ramp_d;
      eor_q        <= eor_d;
      land_q       <= land_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.ladder         = ladder_q;
  assign bus.limit_ypos_min = lmin_q;
  assign bus.limit_ypos_max = lmax_q;
  assign bus.ramp           = ramp_q;
  assign bus.end_of_ramp    = eor_q;
  assign bus.landing_ypos   = land_q;
endmodule
